// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for a 640x480@60 VGA output. Produces the
//   hcount/vcount raster consumed by the scene renderer and takes the
//   renderer's pixel back. It then blanks that pixel outside the active area
//   and aligns it with hsync/vsync so the monitor sees a coherent frame.
//
// Optional feature (macro VGA_TEST_PATTERN_EN):
//   This macro adds the test_sel input. When test_sel is high, rgb_out shows
//   64-px vertical colour bars derived from the delayed hcount instead of
//   pixel_in.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   test_sel    in   test-pattern select (VGA_TEST_PATTERN_EN only)
//   pixel_in    in   [7:0] renderer pixel, valid PIPE_DELAY clks after counters
//   hcount      out  [9:0] current column 0..H_TOTAL-1
//   vcount      out  [9:0] current line 0..V_TOTAL-1
//   pix_en      out  one-clk pixel strobe every CLK_DIV clks
//   hsync       out  horizontal sync, active level SYNC_POL
//   vsync       out  vertical sync, active level SYNC_POL
//   rgb_out     out  [7:0] blanked pixel to DAC
//   frame_start out  one-clk pulse when the raster wraps to (0,0)
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CLK_DIV    = 2,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_sel,
`endif
  input  logic [7:0] pixel_in,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb_out,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  // Keep the prescaler at least one bit wide so CLK_DIV=1 still elaborates.
  localparam int unsigned PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          pix_en_q, pix_en_d;
  logic [9:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic          frame_start_q, frame_start_d;
  logic [PIPE_DELAY-1:0] act_q, hs_q, vs_q;
  logic [7:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [31:0]   hc_ext, vc_ext;
  logic          active, hs_raw, vs_raw;
  logic [7:0]    pix_src;
`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]    hc_pipe_q [PIPE_DELAY];
`endif

  // Prescaler, raster counters and frame pulse
  always_comb begin
    presc_d       = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
    pix_en_d      = (presc_q == PRE_MAX);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      if (hcount_q == H_MAX) begin
        hcount_d = '0;
        if (vcount_q == V_MAX) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // Raw region flags from the current counters (zero-extended compares)
  always_comb begin
    hc_ext = {22'd0, hcount_q};
    vc_ext = {22'd0, vcount_q};
    active = (hc_ext < H_ACTIVE) && (vc_ext < V_ACTIVE);
    hs_raw = (hc_ext >= HS_START) && (hc_ext < HS_END);
    vs_raw = (vc_ext >= VS_START) && (vc_ext < VS_END);
  end

  // Output stage: blank and apply sync polarity to the delayed flags
  always_comb begin
`ifdef VGA_TEST_PATTERN_EN
    pix_src = test_sel ? {hc_pipe_q[PIPE_DELAY-1][8:6], hc_pipe_q[PIPE_DELAY-1][8:6],
                          hc_pipe_q[PIPE_DELAY-1][8:7]}
                       : pixel_in;
`else
    pix_src = pixel_in;
`endif
    rgb_d   = act_q[PIPE_DELAY-1] ? pix_src : 8'd0;
    hsync_d = hs_q[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
    vsync_d = vs_q[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      pix_en_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      act_q         <= '0;
      hs_q          <= '0;
      vs_q          <= '0;
      rgb_q         <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
`ifdef VGA_TEST_PATTERN_EN
      for (int i = 0; i < PIPE_DELAY; i++) hc_pipe_q[i] <= '0;
`endif
    end else begin
      presc_q       <= presc_d;
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      // Alignment shift register runs every clk so its depth matches the
      // renderer latency in clks, independent of the pixel rate.
      act_q[0] <= active;
      hs_q[0]  <= hs_raw;
      vs_q[0]  <= vs_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        act_q[i] <= act_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
`ifdef VGA_TEST_PATTERN_EN
      hc_pipe_q[0] <= hcount_q;
      for (int i = 1; i < PIPE_DELAY; i++) hc_pipe_q[i] <= hc_pipe_q[i-1];
`endif
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign pix_en      = pix_en_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;
  assign frame_start = frame_start_q;

endmodule
